// File: rtl/multi_blink_if.sv
// Control and LED signal bundle for multi_blink: the controller drives enable/mode/shift,
// the blinker returns registered led/tick/flg.
interface multi_blink_if #(
  parameter int CBITS = 28,
  parameter int NCH   = 4
);
  localparam int SBITS = $clog2(CBITS);

  // No handshake: en/mode/shift are level controls sampled on every rising clk edge,
  // and led/tick/flg are registered levels/one-cycle pulses valid for the whole cycle.
  logic                   en;
  logic [2*NCH-1:0]       mode;
  logic [SBITS*NCH-1:0]   shift;
  logic [NCH-1:0]         led;
  logic [NCH-1:0]         tick;
  logic                   flg;

  modport master (output en, mode, shift, input led, tick, flg);
  modport slave  (input en, mode, shift, output led, tick, flg);
endinterface

// File: rtl/multi_blink.sv
// Multi-channel LED blinker: one shared free-running counter, per-channel power-of-two
// rate and OFF/ON/BLINK/PULSE mode, per-channel event tick and counter-wrap flag.
module multi_blink #(
  parameter int CBITS = 28,
  parameter int NCH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  multi_blink_if.slave  bus
);
  localparam int SBITS = $clog2(CBITS);
  localparam logic [SBITS-1:0] EMAX = SBITS'(CBITS - 1);

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_ON    = 2'b01,
    M_BLINK = 2'b10,
    M_PULSE = 2'b11
  } mode_t;

  logic [CBITS-1:0] cnt;
  logic [NCH-1:0]   ph;
  logic [NCH-1:0]   ph_nxt;
  logic [NCH-1:0]   ev;
  logic [NCH-1:0]   led_nxt;
  logic [NCH-1:0]   tick_nxt;
  logic [NCH-1:0]   led_q;
  logic [NCH-1:0]   tick_q;
  logic             flg_q;
  logic [SBITS-1:0] e    [NCH];
  logic [CBITS-1:0] mask [NCH];
  mode_t            m    [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // Oversized shift values clamp to the top counter bit rather than wrapping.
      e[i]    = (bus.shift[SBITS*i +: SBITS] > EMAX) ? EMAX : bus.shift[SBITS*i +: SBITS];
      mask[i] = ~({CBITS{1'b1}} << e[i]);
      ev[i]   = bus.en && ((cnt & mask[i]) == mask[i]);
      m[i]    = mode_t'(bus.mode[2*i +: 2]);

      ph_nxt[i]   = 1'b0;
      led_nxt[i]  = 1'b0;
      tick_nxt[i] = 1'b0;
      case (m[i])
        M_OFF: begin
          led_nxt[i]  = 1'b0;
          tick_nxt[i] = 1'b0;
        end
        M_ON: begin
          led_nxt[i]  = 1'b1;
          tick_nxt[i] = ev[i];
        end
        M_BLINK: begin
          ph_nxt[i]   = ph[i] ^ ev[i];
          led_nxt[i]  = ph[i] ^ ev[i];
          tick_nxt[i] = ev[i];
        end
        M_PULSE: begin
          led_nxt[i]  = ev[i];
          tick_nxt[i] = ev[i];
        end
        default: begin
          led_nxt[i]  = 1'b0;
          tick_nxt[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      ph     <= '0;
      led_q  <= '0;
      tick_q <= '0;
      flg_q  <= 1'b0;
    end else begin
      if (bus.en) cnt <= cnt + CBITS'(1);
      ph     <= ph_nxt;
      led_q  <= led_nxt;
      tick_q <= tick_nxt;
      flg_q  <= bus.en && (cnt == {CBITS{1'b1}});
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;
  assign bus.flg  = flg_q;
endmodule
